// File: rtl/psi_pulse_generator.sv
// psi pulse train source: N_HI high cycles then LOW_CYCLES low.
// Divisor updates are buffered and applied only at period starts.
module psi_pulse_generator #(
  parameter int         DIV_W      = 4,
  parameter logic [3:0] HI_PREFIX  = 4'b1011,
  parameter int         LOW_CYCLES = 8,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             psi,
  output logic             busy,
  output logic             period_done,
  output logic [7:0]       pulse_cnt,
  output logic [DIV_W-1:0] active_div
);

  localparam int HI_W = DIV_W + 4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [DIV_W-1:0] pending_div;
  logic [DIV_W-1:0] next_div;
  logic [HI_W-1:0]  n_hi;
  logic [CNT_W-1:0] hi_last;
  logic [CNT_W-1:0] lo_last;
  logic             start;

  // A load coinciding with a boundary feeds the starting period.
  assign next_div = load ? div : pending_div;
  assign n_hi     = {HI_PREFIX, active_div};
  assign hi_last  = (n_hi == '0) ? CNT_W'(1) : CNT_W'(n_hi);
  assign lo_last  = CNT_W'(LOW_CYCLES);

  // Next-state and phase counter; en only matters in IDLE or at end of LOW.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = HIGH;
          cnt_n   = CNT_W'(1);
          start   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == hi_last) begin
          state_n = LOW;
          cnt_n   = CNT_W'(1);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOW: begin
        if (cnt == lo_last) begin
          if (en) begin
            state_n = HIGH;
            cnt_n   = CNT_W'(1);
            start   = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, registered outputs and divisor buffering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      psi         <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
      pulse_cnt   <= '0;
      active_div  <= '0;
      pending_div <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      psi         <= (state_n == HIGH);
      busy        <= (state_n != IDLE);
      period_done <= (state_n == LOW) && (cnt_n == lo_last);
      if (load) begin
        pending_div <= div;
      end
      if (start) begin
        active_div <= next_div;
        pulse_cnt  <= pulse_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_psi_pulse_generator.sv
// Directed bench for psi_pulse_generator.
// Short-period instance plus one default-parameter instance.
module tb_psi_pulse_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] div;
  logic       load;
  logic       psi;
  logic       busy;
  logic       period_done;
  logic [7:0] pulse_cnt;
  logic [3:0] active_div;

  logic       en2;
  logic [3:0] div2;
  logic       load2;
  logic       psi2;
  logic       busy2;
  logic       pd2;
  logic [7:0] cnt2;
  logic [3:0] adiv2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psi_pulse_generator #(
    .HI_PREFIX (4'b0000),
    .LOW_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .load       (load),
    .psi        (psi),
    .busy       (busy),
    .period_done(period_done),
    .pulse_cnt  (pulse_cnt),
    .active_div (active_div)
  );

  psi_pulse_generator dut2 (
    .clk        (clk),
    .rst        (rst),
    .en         (en2),
    .div        (div2),
    .load       (load2),
    .psi        (psi2),
    .busy       (busy2),
    .period_done(pd2),
    .pulse_cnt  (cnt2),
    .active_div (adiv2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Entered right after psi rose; leaves at next rise or in IDLE.
  task automatic run_period(input int ehi, input int elo,
                            input int ecnt, input int ediv,
                            input bit ld, input logic [3:0] lv,
                            input bit drop);
    int hi;
    int lo;
    int pd;
    chk("rise_psi", 32'(psi), 1);
    chk("rise_cnt", 32'(pulse_cnt), ecnt);
    chk("rise_div", 32'(active_div), ediv);
    hi = 0;
    while (psi === 1'b1 && hi < 400) begin
      if (hi == 0 && ld) begin
        load = 1'b1;
        div  = lv;
      end else begin
        load = 1'b0;
      end
      if (hi == 1 && drop) en = 1'b0;
      hi++;
      step();
    end
    load = 1'b0;
    lo = 0;
    pd = -1;
    while (psi === 1'b0 && busy === 1'b1 && lo < 20) begin
      if (period_done === 1'b1) pd = lo;
      lo++;
      step();
    end
    chk("hi_len", hi, ehi);
    chk("lo_len", lo, elo);
    chk("pd_pos", pd, elo - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi2;
    int lo2;
    int pdp;
    rst   = 1'b1;
    en    = 1'b1;
    load  = 1'b1;
    div   = 4'd9;
    en2   = 1'b1;
    load2 = 1'b1;
    div2  = 4'd7;
    step();
    chk("rst1_psi", 32'(psi), 0);
    chk("rst1_busy", 32'(busy), 0);
    step();
    chk("rst2_psi", 32'(psi), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_cnt", 32'(pulse_cnt), 0);
    chk("rst2_div", 32'(active_div), 0);
    chk("rst2_pd", 32'(period_done), 0);
    chk("rst2_psi2", 32'(psi2), 0);
    rst   = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    en2   = 1'b0;
    load2 = 1'b0;
    step();
    chk("idle_psi", 32'(psi), 0);
    chk("idle_busy", 32'(busy), 0);

    div  = 4'd4;
    load = 1'b1;
    step();
    load = 1'b0;
    en   = 1'b1;
    step();
    run_period(4, 3, 1, 4, 1'b0, 4'd0, 1'b0);
    run_period(4, 3, 2, 4, 1'b0, 4'd0, 1'b0);

    run_period(4, 3, 3, 4, 1'b1, 4'd6, 1'b0);
    run_period(6, 3, 4, 6, 1'b0, 4'd0, 1'b0);

    run_period(6, 3, 5, 6, 1'b0, 4'd0, 1'b1);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_psi", 32'(psi), 0);
    step();
    step();
    chk("hold_psi", 32'(psi), 0);
    chk("hold_busy", 32'(busy), 0);
    chk("hold_cnt", 32'(pulse_cnt), 5);
    en = 1'b1;
    step();
    run_period(6, 3, 6, 6, 1'b1, 4'd0, 1'b0);

    run_period(1, 3, 7, 0, 1'b0, 4'd0, 1'b0);

    repeat ((256 - 8) * 4) step();
    chk("wrap_cnt", 32'(pulse_cnt), 0);
    chk("wrap_psi", 32'(psi), 1);
    run_period(1, 3, 0, 0, 1'b1, 4'd5, 1'b0);
    chk("p257_cnt", 32'(pulse_cnt), 1);
    chk("p257_div", 32'(active_div), 5);
    step();
    step();
    chk("midhi_psi", 32'(psi), 1);
    rst = 1'b1;
    step();
    chk("mrst_psi", 32'(psi), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_cnt", 32'(pulse_cnt), 0);
    chk("mrst_div", 32'(active_div), 0);
    rst = 1'b0;
    en  = 1'b0;
    step();
    chk("post_psi", 32'(psi), 0);
    chk("post_busy", 32'(busy), 0);

    div2  = 4'd5;
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    en2   = 1'b1;
    step();
    chk("d_psi", 32'(psi2), 1);
    chk("d_div", 32'(adiv2), 5);
    chk("d_cnt", 32'(cnt2), 1);
    en2 = 1'b0;
    hi2 = 0;
    while (psi2 === 1'b1 && hi2 < 400) begin
      hi2++;
      step();
    end
    lo2 = 0;
    pdp = -1;
    while (psi2 === 1'b0 && busy2 === 1'b1 && lo2 < 40) begin
      if (pd2 === 1'b1) pdp = lo2;
      lo2++;
      step();
    end
    chk("d_hi", hi2, 181);
    chk("d_lo", lo2, 8);
    chk("d_pd", pdp, 7);
    chk("d_busy", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
